spec_tag_queue: RTL
===================

Name: spec_tag_queue

Overview:
- Upstream neighbour of the speculative-data label-propagation stage.
- Allocates a tag to every speculative operation, keeps in-flight tags in program order, and retires them as resolutions arrive in order.
- On a misspeculation it broadcasts the squashed tag on l_valid/l_status. The downstream stage compares that tag against its own data tag to derive isMisspec.
- Supplies the tags the downstream stage stores alongside its speculative data.

Parameters:
- DEPTH, 8, number of in-flight speculative entries; power of 2; must be <= 2**TAG_W.
- TAG_W, 4, tag width; must match the downstream l_status width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- issue_valid  input  1  request to start a new speculation.
- issue_ready  output  1  queue can accept an issue this cycle.
- issue_tag  output  TAG_W  tag assigned to the issue accepted this cycle.
- resolve_valid  input  1  oldest in-flight speculation resolves.
- resolve_mispred  input  1  qualifies resolve_valid: 1 = misspeculated, 0 = correct.
- l_valid  output  1  registered misspeculation broadcast.
- l_status  output  TAG_W  squashed tag; meaningful only when l_valid = 1.
- commit_valid  output  1  registered pulse when the head resolves correctly.
- commit_tag  output  TAG_W  tag that was committed.
- count  output  $clog2(DEPTH)+1  current occupancy.
- resolve_err  output  1  sticky flag: a resolution arrived while the queue was empty.

Behaviour:
- Reset (asynchronous, rst_n low):
  - queue empty, count = 0, next_tag = 0;
  - l_valid, commit_valid, resolve_err = 0;
  - l_status and commit_tag = 0.
- issue_ready = (count != DEPTH) && !(resolve_valid && resolve_mispred). This is combinational.
- issue_tag = next_tag (combinational).
- An issue is accepted when issue_valid && issue_ready:
  - tag is written at the tail;
  - next_tag increments and wraps 2**TAG_W-1 -> 0.
- next_tag is never rewound on a flush. Tags therefore stay unique among live entries and any stale downstream copies.
- Correct resolve (resolve_valid && !resolve_mispred && count != 0):
  - head is popped;
  - next cycle: commit_valid = 1, commit_tag = old head tag, l_valid = 0.
- Mispredicted resolve (resolve_valid && resolve_mispred && count != 0):
  - next cycle: l_valid = 1, l_status = head tag;
  - the entire queue (head and all younger entries) is flushed, count = 0;
  - an issue in the same cycle is refused because issue_ready = 0.
- l_valid and commit_valid are single-cycle pulses. l_status holds its value until the next mispredict.
- Resolve while count = 0:
  - ignored, with no pops and no pulses;
  - resolve_err is set to 1 and held until reset.
- Full (count = DEPTH) with a simultaneous correct resolve: the pop occurs, but the issue is not accepted that cycle. issue_ready is not recomputed from the pop.
- Empty with a simultaneous issue and a correct resolve: the resolve counts as an error (the queue was empty at the cycle start); the issue is accepted.
- Non-full, non-empty, issue plus correct resolve in the same cycle: push and pop both happen; count is unchanged.
- Read and write pointers are DEPTH-modulo with wrap. Full and empty are distinguished by count.
- rst_n asserted mid-operation: all in-flight entries are discarded immediately, with no broadcast.

Optional Feature:
- Macro SPEC_TAG_STATS_EN.
- Defined:
  - adds output mispred_cnt [15:0] and output commit_cnt [15:0];
  - each counter increments by 1 in the cycle its pulse asserts and saturates at 16'hFFFF;
  - both reset to 0.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Package spec_tag_pkg:
  - TAG_W default constant;
  - typedef spec_tag_t (logic [TAG_W-1:0]);
  - typedef resolve_kind_e {RES_NONE, RES_OK, RES_MISPRED}.
- One sub-module, spec_tag_fifo:
  - circular buffer with push, pop, flush, count, head output;
  - flush takes priority over push.
- The top-level holds the tag allocator, the resolve decode, the registered broadcast outputs and the optional stats.

Test Plan:
1. Reset, then issue 3 ops -> issue_tag 0,1,2; count = 3; no l_valid.
2. From test 1 state, 2 correct resolves -> commit_valid pulses with commit_tag 0 then 1; count = 1.
3. Issue tags up to a full queue of 8 -> issue_ready = 0; a further issue_valid is ignored; a correct resolve in that cycle pops, count = 7, and the issue is not taken.
4. Queue holds tags 5,6,7, then a mispred resolve plus issue_valid in the same cycle -> next cycle l_valid = 1, l_status = 5; count = 0; the issue is refused; the next accepted issue gets tag 8.
5. Issue 20 ops with interleaved resolves -> tags wrap 15 -> 0; no duplicate tags among live entries.
6. Resolve on an empty queue -> resolve_err = 1 and stays 1; no pulses. Assert rst_n low mid-queue -> count = 0, resolve_err = 0, immediately and asynchronously.

Source files
------------

// File: rtl/spec_tag_pkg.sv
// Shared types for the speculative tag queue: default tag width, tag type, resolve decode.
// Pure definitions; no logic, latency or flow control of its own.
package spec_tag_pkg;

  localparam int SPEC_TAG_W = 4;

  typedef logic [SPEC_TAG_W-1:0] spec_tag_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_OK,
    RES_MISPRED
  } resolve_kind_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/spec_tag_fifo.sv
// Circular tag buffer with push/pop/flush; head is combinational from storage, count/pointers update next cycle.
// Push is dropped when full and pop when empty; flush wins over a same-cycle push.
module spec_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               push_dat_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/spec_tag_queue.sv
// Speculative tag allocator/queue; issue path is combinational, commit/misspec broadcasts register one cycle later.
// Issue is refused when full or during a mispredict resolve; SPEC_TAG_STATS_EN adds saturating event counters.
module spec_tag_queue
  import spec_tag_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = SPEC_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  output logic [TAG_W-1:0]         issue_tag,
  input  logic                     resolve_valid,
  input  logic                     resolve_mispred,
  output logic                     l_valid,
  output logic [TAG_W-1:0]         l_status,
  output logic                     commit_valid,
  output logic [TAG_W-1:0]         commit_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     resolve_err
`ifdef SPEC_TAG_STATS_EN
  ,
  output logic [15:0]              mispred_cnt,
  output logic [15:0]              commit_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [TAG_W-1:0] next_tag_q, next_tag_d;
  logic             l_valid_q, l_valid_d;
  logic [TAG_W-1:0] l_status_q, l_status_d;
  logic             commit_valid_q, commit_valid_d;
  logic [TAG_W-1:0] commit_tag_q, commit_tag_d;
  logic             resolve_err_q, resolve_err_d;

  logic [TAG_W-1:0] head_tag;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty;
  logic             issue_fire;
  resolve_kind_e    res_kind;

  // Readiness deliberately ignores a same-cycle pop so the full case never chains pop into push.
  assign issue_ready = !fifo_full && !(resolve_valid && resolve_mispred);
  assign issue_tag   = next_tag_q;
  assign issue_fire  = issue_valid && issue_ready;

  always_comb begin
    res_kind = RES_NONE;
    if (resolve_valid && !fifo_empty) begin
      res_kind = resolve_mispred ? RES_MISPRED : RES_OK;
    end
  end

  spec_tag_fifo #(
    .DEPTH (DEPTH),
    .W     (TAG_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (issue_fire),
    .push_dat_i (next_tag_q),
    .pop_i      (res_kind == RES_OK),
    .flush_i    (res_kind == RES_MISPRED),
    .head_o     (head_tag),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    next_tag_d     = next_tag_q;
    l_valid_d      = 1'b0;
    l_status_d     = l_status_q;
    commit_valid_d = 1'b0;
    commit_tag_d   = commit_tag_q;
    resolve_err_d  = resolve_err_q;

    // Tags are never rewound, so a flushed tag cannot alias a live or stale downstream copy.
    if (issue_fire) next_tag_d = next_tag_q + TAG_W'(1);

    case (res_kind)
      RES_OK: begin
        commit_valid_d = 1'b1;
        commit_tag_d   = head_tag;
      end
      RES_MISPRED: begin
        l_valid_d  = 1'b1;
        l_status_d = head_tag;
      end
      default: ;
    endcase

    if (resolve_valid && fifo_empty) resolve_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_tag_q     <= '0;
      l_valid_q      <= 1'b0;
      l_status_q     <= '0;
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      resolve_err_q  <= 1'b0;
    end else begin
      next_tag_q     <= next_tag_d;
      l_valid_q      <= l_valid_d;
      l_status_q     <= l_status_d;
      commit_valid_q <= commit_valid_d;
      commit_tag_q   <= commit_tag_d;
      resolve_err_q  <= resolve_err_d;
    end
  end

  assign l_valid      = l_valid_q;
  assign l_status     = l_status_q;
  assign commit_valid = commit_valid_q;
  assign commit_tag   = commit_tag_q;
  assign count        = fifo_count;
  assign resolve_err  = resolve_err_q;

`ifdef SPEC_TAG_STATS_EN
  logic [15:0] mispred_cnt_q, mispred_cnt_d;
  logic [15:0] commit_cnt_q, commit_cnt_d;

  // Counters advance on the same edge that raises the pulse, so they track the pulses exactly.
  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    commit_cnt_d  = commit_cnt_q;
    if (l_valid_d)      mispred_cnt_d = sat_inc16(mispred_cnt_q);
    if (commit_valid_d) commit_cnt_d  = sat_inc16(commit_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispred_cnt_q <= '0;
      commit_cnt_q  <= '0;
    end else begin
      mispred_cnt_q <= mispred_cnt_d;
      commit_cnt_q  <= commit_cnt_d;
    end
  end

  assign mispred_cnt = mispred_cnt_q;
  assign commit_cnt  = commit_cnt_q;
`endif

endmodule
